// File: rtl/stream_rr_arbiter_pkg.sv
// Shared stream types: arbiter FSM state encoding and the index-width helper.
// The top-level file names the optional packet-mode macro, STREAM_ARB_PACKET_EN.
package stream_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_PKT  = 2'd2
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Rotating find-first-set: the first asserted request at or after start_i, wrapping modulo NUM_INPUTS.
// Purely combinational with no flow control; reusable by any round-robin arbiter.
module rr_prio_select
  import stream_rr_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int IDX_W      = idx_w(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [IDX_W-1:0]      start_i,
  output logic                  found_o,
  output logic [IDX_W-1:0]      idx_o
);

  // One extra bit so start + offset cannot overflow before the explicit wrap.
  localparam int           CW  = IDX_W + 1;
  localparam logic [CW-1:0] N_W = CW'(NUM_INPUTS);

  logic [CW-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    cand    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = {1'b0, start_i} + CW'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!found_o && req_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Zero-latency N:1 round-robin valid/ready arbiter; a grant stalled by out_ready_i stays locked until it handshakes.
// Define STREAM_ARB_PACKET_EN to also hold the grant until the beat carrying in_last_i completes.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = idx_w(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            in_valid_i,
  output logic [NUM_INPUTS-1:0]            in_ready_o,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_INPUTS-1:0]            in_last_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic                             out_last_o,
  output logic [IDX_W-1:0]                 out_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             locked;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             hs;
  logic [IDX_W-1:0] next_ptr;

  logic [DATA_WIDTH-1:0] data_arr [NUM_INPUTS];

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
    assign data_arr[g] = in_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_prio_select #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_prio (
    .req_i   (in_valid_i),
    .start_i (ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  // A locked grant follows its own input's valid even if it drops, so the output never switches source mid-transfer.
  always_comb begin
    locked    = (state_q != ARB_IDLE);
    grant_idx = locked ? lock_idx_q : sel_idx;
    grant_vld = locked ? in_valid_i[lock_idx_q] : sel_found;
  end

  always_comb begin
    out_valid_o = grant_vld & ~rst;
    out_idx_o   = grant_idx;
    out_data_o  = data_arr[grant_idx];
    out_last_o  = in_last_i[grant_idx];
    hs          = out_valid_o & out_ready_i;
    in_ready_o  = '0;
    in_ready_o[grant_idx] = hs;
    next_ptr    = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ARB_IDLE, ARB_HOLD: begin
        if (hs) begin
`ifdef STREAM_ARB_PACKET_EN
          if (!out_last_o) begin
            state_d    = ARB_PKT;
            lock_idx_d = grant_idx;
          end else begin
            state_d = ARB_IDLE;
            ptr_d   = next_ptr;
          end
`else
          state_d = ARB_IDLE;
          ptr_d   = next_ptr;
`endif
        end else if (grant_vld) begin
          state_d    = ARB_HOLD;
          lock_idx_d = grant_idx;
        end
      end
`ifdef STREAM_ARB_PACKET_EN
      ARB_PKT: begin
        if (hs && out_last_o) begin
          state_d = ARB_IDLE;
          ptr_d   = next_ptr;
        end
      end
`endif
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifndef SYNTHESIS
  hold_valid_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB_HOLD) |-> in_valid_i[lock_idx_q])
    else $error("stream_rr_arbiter: locked input %0d dropped valid before handshake", lock_idx_q);
`endif

endmodule
